// File: rtl/xadc_drp_scheduler_pkg.sv
// Shared constants for the XADC DRP read scheduler: FSM encoding,
// slot-to-DRP-address map and the default read timeout.
package xadc_drp_scheduler_pkg;

    localparam int TIMEOUT_CYC_DEF = 255;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;
    localparam logic [1:0] ST_STORE    = 2'd3;

    localparam logic [6:0] ADDR_SLOT0 = 7'h16;
    localparam logic [6:0] ADDR_SLOT1 = 7'h17;
    localparam logic [6:0] ADDR_SLOT2 = 7'h1E;
    localparam logic [6:0] ADDR_SLOT3 = 7'h1F;

    function automatic logic [6:0] slot_addr(input logic [1:0] slot);
        case (slot)
            2'd0:    slot_addr = ADDR_SLOT0;
            2'd1:    slot_addr = ADDR_SLOT1;
            2'd2:    slot_addr = ADDR_SLOT2;
            2'd3:    slot_addr = ADDR_SLOT3;
            default: slot_addr = ADDR_SLOT0;
        endcase
    endfunction

endpackage

// File: rtl/xadc_drp_scheduler_rr_pick.sv
// Combinational round-robin selector: first enabled slot strictly after
// the pointer, wrapping 3->0, with the pointer slot itself checked last.
module xadc_rr_pick
    import xadc_drp_scheduler_pkg::*;
(
    input  logic [1:0] ptr,
    input  logic [3:0] en,
    output logic [1:0] slot,
    output logic       any_valid
);

    logic [1:0] cand_s;

    // Scan farthest-to-nearest so the nearest enabled slot is written last.
    always_comb begin
        slot      = ptr;
        any_valid = 1'b0;
        cand_s    = ptr;
        for (int i = 4; i >= 1; i--) begin
            cand_s = ptr + 2'(i);
            if (en[cand_s]) begin
                slot      = cand_s;
                any_valid = 1'b1;
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/xadc_drp_scheduler.sv
// Schedules round-robin DRP reads of the XADC aux channels on each
// end-of-conversion and keeps the latest 12-bit result per slot.
module xadc_drp_scheduler
    import xadc_drp_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic [3:0]  ch_enable,
    input  logic        eoc_in,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    output logic        dwe_out,
    output logic [15:0] di_out,
    input  logic [15:0] do_in,
    input  logic        drdy_in,
    input  logic [1:0]  rd_sel,
    output logic [11:0] rd_data,
    output logic        sample_strobe,
    output logic [1:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  state_r;
    logic [1:0]  slot_r;
    logic [1:0]  ptr_r;
    logic        pending_r;
    logic [15:0] cnt_r;
    logic [11:0] bank_r [4];
    logic [1:0]  pick_slot_s;
    logic        pick_valid_s;
    logic        busy_s;
    logic        overrun_set_s;
    logic        timeout_set_s;

    xadc_rr_pick u_pick (
        .ptr       (ptr_r),
        .en        (ch_enable),
        .slot      (pick_slot_s),
        .any_valid (pick_valid_s)
    );

    assign dwe_out       = 1'b0;
    assign di_out        = 16'h0000;
    assign rd_data       = bank_r[rd_sel];
    assign busy_s        = (state_r != ST_IDLE);
    assign overrun_set_s = eoc_in && busy_s && pending_r;
    assign timeout_set_s = (state_r == ST_WAIT_RDY) && !drdy_in && (cnt_r == TO_LAST);

    // Main read sequencer, result bank and sample outputs.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            slot_r        <= 2'd0;
            ptr_r         <= 2'd3;
            cnt_r         <= 16'd0;
            den_out       <= 1'b0;
            daddr_out     <= ADDR_SLOT0;
            sample_strobe <= 1'b0;
            sample_ch     <= 2'd0;
            sample_data   <= 12'd0;
            for (int i = 0; i < 4; i++) begin
                bank_r[i] <= 12'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((eoc_in || pending_r) && pick_valid_s) begin
                        state_r   <= ST_ISSUE;
                        slot_r    <= pick_slot_s;
                        daddr_out <= slot_addr(pick_slot_s);
                        den_out   <= 1'b1;
                        cnt_r     <= 16'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    den_out <= 1'b0;
                    cnt_r   <= 16'd0;
                    state_r <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (drdy_in) begin
                        bank_r[slot_r] <= do_in[15:4];
                        sample_strobe  <= 1'b1;
                        sample_ch      <= slot_r;
                        sample_data    <= do_in[15:4];
                        ptr_r          <= slot_r;
                        state_r        <= ST_STORE;
                    end else if (cnt_r == TO_LAST) begin
                        // Abandon the read but still advance past this slot.
                        ptr_r   <= slot_r;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_STORE: begin
                    sample_strobe <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    den_out       <= 1'b0;
                    sample_strobe <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    // One-deep request queue; consumed (or discarded) whenever IDLE sees work.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
        end else if (!busy_s) begin
            pending_r <= 1'b0;
        end else if (eoc_in) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun     <= overrun_set_s || (overrun && !err_clr);
            timeout_err <= timeout_set_s || (timeout_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Scoreboard bench for xadc_drp_scheduler: expected DRP addresses and
// samples are queued by the stimulus and checked by a negedge monitor.
module tb_xadc_drp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ch_enable = 4'b0000;
    logic        eoc_in = 1'b0;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic        dwe_out;
    logic [15:0] di_out;
    logic [15:0] do_in = 16'h0000;
    logic        drdy_in = 1'b0;
    logic [1:0]  rd_sel = 2'd0;
    logic [11:0] rd_data;
    logic        sample_strobe;
    logic [1:0]  sample_ch;
    logic [11:0] sample_data;
    logic        overrun;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad = 0;

    logic [6:0]  exp_addr_q [$];
    logic [13:0] exp_smp_q [$];

    xadc_drp_scheduler dut (
        .CLK100MHZ     (clk),
        .rst_n         (rst_n),
        .ch_enable     (ch_enable),
        .eoc_in        (eoc_in),
        .daddr_out     (daddr_out),
        .den_out       (den_out),
        .dwe_out       (dwe_out),
        .di_out        (di_out),
        .do_in         (do_in),
        .drdy_in       (drdy_in),
        .rd_sel        (rd_sel),
        .rd_data       (rd_data),
        .sample_strobe (sample_strobe),
        .sample_ch     (sample_ch),
        .sample_data   (sample_data),
        .overrun       (overrun),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DRP enable and every sample strobe must match the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (den_out) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_den", 32'(daddr_out), 32'hFFFF_FFFF);
                end else begin
                    chk("den_addr", 32'(daddr_out), 32'(exp_addr_q.pop_front()));
                end
            end
            if (sample_strobe) begin
                if (exp_smp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'({sample_ch, sample_data}), 32'hFFFF_FFFF);
                end else begin
                    chk("sample", 32'({sample_ch, sample_data}), 32'(exp_smp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_den"}, 32'(den_out), 32'd0);
        chk({tag, "_daddr"}, 32'(daddr_out), 32'h16);
        chk({tag, "_strobe"}, 32'(sample_strobe), 32'd0);
        chk({tag, "_sch"}, 32'(sample_ch), 32'd0);
        chk({tag, "_sdata"}, 32'(sample_data), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
        chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            chk({tag, "_bank"}, 32'(rd_data), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        eoc_in = 1'b0;
        drdy_in = 1'b0;
        err_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_eoc();
        eoc_in = 1'b1;
        tick(1);
        eoc_in = 1'b0;
    endtask

    task automatic wait_den(input string name);
        int n;
        n = 0;
        while (!den_out && n < 50) begin
            tick(1);
            n++;
        end
        if (!den_out) begin
            chk({name, "_den_timeout"}, 32'(den_out), 32'd1);
        end
    endtask

    task automatic respond(input logic [15:0] data, input int dly);
        tick(dly);
        do_in = data;
        drdy_in = 1'b1;
        tick(1);
        drdy_in = 1'b0;
        do_in = 16'h0000;
    endtask

    // One full read: eoc, den on the next cycle, drdy dly cycles later.
    task automatic full_read(input logic [6:0] addr, input logic [1:0] ch, input logic [15:0] data);
        exp_addr_q.push_back(addr);
        exp_smp_q.push_back({ch, data[15:4]});
        pulse_eoc();
        chk("den_latency", 32'(den_out), 32'd1);
        respond(data, 3);
        tick(3);
    endtask

    logic [6:0]  addr_tab [4] = '{7'h16, 7'h17, 7'h1E, 7'h1F};
    logic [15:0] data_tab [4] = '{16'hABC0, 16'h1234, 16'h5670, 16'h9AB0};

    initial begin
        int cyc;
        rd_sel = 2'd0;
        #2;
        chk("async_reset_den", 32'(den_out), 32'd0);
        tick(2);
        check_reset_vals("rst");
        chk("dwe", 32'(dwe_out), 32'd0);
        chk("di", 32'(di_out), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // All four slots in order.
        ch_enable = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            full_read(addr_tab[k], 2'(k), data_tab[k]);
        end
        for (int k = 0; k < 4; k++) begin
            rd_sel = 2'(k);
            #1;
            chk("bank_all", 32'(rd_data), 32'(data_tab[k][15:4]));
        end

        // Alternating slots 0 and 2; slots 1 and 3 untouched.
        do_reset();
        ch_enable = 4'b0101;
        full_read(7'h16, 2'd0, 16'h0010);
        full_read(7'h1E, 2'd2, 16'hFFF0);
        full_read(7'h16, 2'd0, 16'h8005);
        full_read(7'h1E, 2'd2, 16'h4447);
        ch_enable = 4'b0000;
        rd_sel = 2'd0; #1; chk("bank0_alt", 32'(rd_data), 32'h800);
        rd_sel = 2'd1; #1; chk("bank1_alt", 32'(rd_data), 32'h000);
        rd_sel = 2'd2; #1; chk("bank2_alt", 32'(rd_data), 32'h444);
        rd_sel = 2'd3; #1; chk("bank3_alt", 32'(rd_data), 32'h000);

        // Timeout: no drdy, flag after 255 WAIT_RDY cycles, pointer advances.
        do_reset();
        ch_enable = 4'b1111;
        exp_addr_q.push_back(7'h16);
        pulse_eoc();
        chk("den_latency_tmo", 32'(den_out), 32'd1);
        cyc = 0;
        for (int i = 1; i <= 400; i++) begin
            tick(1);
            if (timeout_err && cyc == 0) begin
                cyc = i;
                break;
            end
        end
        chk("timeout_cycles", 32'(cyc), 32'd256);
        chk("timeout_flag", 32'(timeout_err), 32'd1);
        drdy_in = 1'b1;
        do_in = 16'h7770;
        tick(1);
        drdy_in = 1'b0;
        tick(2);
        rd_sel = 2'd0; #1; chk("bank0_after_tmo", 32'(rd_data), 32'h000);
        full_read(7'h17, 2'd1, 16'h3210);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("timeout_clr", 32'(timeout_err), 32'd0);

        // Overrun: two eoc during a read -> flag plus exactly one extra read.
        do_reset();
        ch_enable = 4'b1111;
        exp_addr_q.push_back(7'h16);
        exp_addr_q.push_back(7'h17);
        exp_smp_q.push_back({2'd0, 12'h111});
        exp_smp_q.push_back({2'd1, 12'h222});
        pulse_eoc();
        pulse_eoc();
        tick(1);
        chk("ovr_pending_only", 32'(overrun), 32'd0);
        pulse_eoc();
        chk("ovr_set", 32'(overrun), 32'd1);
        respond(16'h1110, 1);
        tick(1);
        wait_den("ovr_extra");
        respond(16'h2220, 2);
        tick(12);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // No channels enabled: eoc discarded, no DRP activity.
        do_reset();
        ch_enable = 4'b0000;
        pulse_eoc();
        for (int i = 0; i < 6; i++) begin
            chk("no_den", 32'(den_out), 32'd0);
            tick(1);
        end
        chk("no_en_ovr", 32'(overrun), 32'd0);

        // Reset mid-read abandons it; late drdy ignored; restart at slot 0.
        do_reset();
        ch_enable = 4'b1111;
        full_read(7'h16, 2'd0, 16'h0F00);
        exp_addr_q.push_back(7'h17);
        pulse_eoc();
        tick(2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick(1);
        rst_n = 1'b1;
        respond(16'h5550, 0);
        tick(2);
        rd_sel = 2'd1; #1; chk("midrst_bank1", 32'(rd_data), 32'h000);
        full_read(7'h16, 2'd0, 16'hC3A0);
        rd_sel = 2'd0; #1; chk("midrst_bank0", 32'(rd_data), 32'hC3A);

        tick(4);
        chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("smp_q_empty", 32'(exp_smp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
